// File: rtl/ser_demux_n_pkg.sv
// ser_demux_pkg: shared types and constants for the ser_demux_n serial packet
// demultiplexer (state encoding, seven-segment glyph table, synchroniser floor).
package ser_demux_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    LEN  = 3'd2,
    DATA = 3'd3,
    PAR  = 3'd4,
    END  = 3'd5
  } state_t;

  // Fewest synchroniser flops that still give a usable metastability window.
  localparam int SYNC_MIN_STAGES = 2;

  // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [6:0] SSD_GLYPH [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] ssd_glyph(input logic [3:0] v);
    return SSD_GLYPH[v];
  endfunction

endpackage

// File: rtl/ser_demux_n_if.sv
// ser_demux_n_if: board-side signal bundle of ser_demux_n. The slave modport is
// the demultiplexer itself; the master modport is whatever drives the push-button
// and serial line and watches the channel/SSD outputs. The err signal exists
// only when PARITY_EN is defined.
interface ser_demux_n_if #(
  parameter int ADDR_W = 2
);
  localparam int NCH = 2 ** ADDR_W;

  logic           SerIn;
  logic           clkPB;
  logic [NCH-1:0] port_sel;
  logic [NCH-1:0] ser_out;
  logic           SerOutValid;
  logic           done;
  logic [6:0]     ssd_result;
`ifdef PARITY_EN
  logic           err;

  modport master (
    output SerIn, clkPB,
    input  port_sel, ser_out, SerOutValid, done, ssd_result, err
  );

  modport slave (
    input  SerIn, clkPB,
    output port_sel, ser_out, SerOutValid, done, ssd_result, err
  );
`else
  modport master (
    output SerIn, clkPB,
    input  port_sel, ser_out, SerOutValid, done, ssd_result
  );

  modport slave (
    input  SerIn, clkPB,
    output port_sel, ser_out, SerOutValid, done, ssd_result
  );
`endif

endinterface

// File: rtl/ser_demux_n_pb_edge_sync.sv
// pb_edge_sync: brings the asynchronous push-button strobe and serial data into
// the clock domain and turns each synchronised rising edge of the strobe into a
// one-clock bit_en, with the synchronised data bit registered alongside it.
module pb_edge_sync
  import ser_demux_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic pb,
  input  logic din,
  output logic bit_en,
  output logic bit_val
);

  localparam int N = (STAGES < SYNC_MIN_STAGES) ? SYNC_MIN_STAGES : STAGES;

  logic [N-1:0] pb_p0;
  logic [N-1:0] din_p0;
  logic         pb_prev_p1;

  // Synchroniser chains, shifting from bit 0 towards bit N-1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pb_p0  <= '0;
      din_p0 <= '0;
    end else begin
      pb_p0  <= {pb_p0[N-2:0], pb};
      din_p0 <= {din_p0[N-2:0], din};
    end
  end

  // ---- stage p1: rising-edge detect, bit_en and data registered together ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pb_prev_p1 <= 1'b0;
      bit_en     <= 1'b0;
      bit_val    <= 1'b0;
    end else begin
      pb_prev_p1 <= pb_p0[N-1];
      bit_en     <= pb_p0[N-1] & ~pb_prev_p1;
      bit_val    <= din_p0[N-1];
    end
  end

endmodule

// File: rtl/ser_demux_n.sv
// ser_demux_n: serial packet demultiplexer. Packets are a 0 start bit, ADDR_W
// address bits, CNT_W length bits and that many payload bits, all MSB first,
// one bit per push-button strobe. Payload is steered to ser_out[addr] and the
// remaining count is shown on a seven-segment digit.
// Optional feature macro: PARITY_EN (adds an even-parity bit and sticky err).
module ser_demux_n
  import ser_demux_pkg::*;
#(
  parameter int ADDR_W      = 2,
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clock,
  input  logic          reset,
  ser_demux_n_if.slave  io
);

  localparam int NCH  = 2 ** ADDR_W;
  localparam int BC_W = (ADDR_W > CNT_W) ? ADDR_W : CNT_W;
  localparam logic [BC_W-1:0] ADDR_LAST = BC_W'(ADDR_W - 1);
  localparam logic [BC_W-1:0] LEN_LAST  = BC_W'(CNT_W - 1);

`ifdef PARITY_EN
  localparam state_t TAIL = PAR;
`else
  localparam state_t TAIL = END;
`endif

  // Remaining-count decrement that floors at zero.
  function automatic logic [CNT_W-1:0] dec_floor(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  logic           bit_en;
  logic           bit_val;

  state_t         state;
  state_t         state_nxt;

  logic [BC_W-1:0]   cnt;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remain;
  logic [NCH-1:0]    port_sel;
  logic [NCH-1:0]    ser_out;
  logic              out_vld;
  logic              done;

  logic [ADDR_W-1:0] addr_nxt;
  logic [CNT_W-1:0]  len_nxt;

  logic start_bit;
  logic addr_shift;
  logic len_shift;
  logic data_bit;
  logic end_st;

`ifdef PARITY_EN
  logic par_acc;
  logic err;
  logic par_bit;
`endif

  pb_edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock   (clock),
    .reset   (reset),
    .pb      (io.clkPB),
    .din     (io.SerIn),
    .bit_en  (bit_en),
    .bit_val (bit_val)
  );

  // Field registers with the incoming bit shifted in at the LSB.
  assign addr_nxt = ADDR_W'({addr, bit_val});
  assign len_nxt  = CNT_W'({remain, bit_val});

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; every transition except END->IDLE waits for a strobe.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bit_en && !bit_val)          state_nxt = ADDR;
      ADDR: if (bit_en && cnt == ADDR_LAST)  state_nxt = LEN;
      LEN:  if (bit_en && cnt == LEN_LAST)   state_nxt = (len_nxt == '0) ? TAIL : DATA;
      DATA: if (bit_en && remain <= CNT_W'(1)) state_nxt = TAIL;
`ifdef PARITY_EN
      PAR:  if (bit_en)                      state_nxt = END;
`endif
      END:                                   state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  // Per-state datapath strobes.
  always_comb begin
    start_bit  = 1'b0;
    addr_shift = 1'b0;
    len_shift  = 1'b0;
    data_bit   = 1'b0;
    end_st     = 1'b0;
`ifdef PARITY_EN
    par_bit    = 1'b0;
`endif
    unique case (state)
      IDLE:    start_bit  = bit_en & ~bit_val;
      ADDR:    addr_shift = bit_en;
      LEN:     len_shift  = bit_en;
      DATA:    data_bit   = bit_en;
`ifdef PARITY_EN
      PAR:     par_bit    = bit_en;
`endif
      END:     end_st     = 1'b1;
      default: ;
    endcase
  end

  // Field counter, address/length capture, payload routing and packet end.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      addr     <= '0;
      remain   <= '0;
      port_sel <= '0;
      ser_out  <= '0;
      out_vld  <= 1'b0;
      done     <= 1'b0;
    end else begin
      out_vld <= data_bit;
      done    <= end_st;
      if (start_bit) begin
        cnt <= '0;
      end
      if (addr_shift) begin
        addr <= addr_nxt;
        if (cnt == ADDR_LAST) begin
          cnt      <= '0;
          port_sel <= NCH'(1) << addr_nxt;
        end else begin
          cnt <= cnt + BC_W'(1);
        end
      end
      if (len_shift) begin
        remain <= len_nxt;
        cnt    <= (cnt == LEN_LAST) ? '0 : cnt + BC_W'(1);
      end
      if (data_bit) begin
        ser_out <= NCH'(bit_val) << addr;
        remain  <= dec_floor(remain);
      end
      if (end_st) begin
        port_sel <= '0;
        ser_out  <= '0;
        remain   <= '0;
      end
    end
  end

`ifdef PARITY_EN
  // Running XOR of address, length and payload bits; err latches a mismatch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      par_acc <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (start_bit) begin
        par_acc <= 1'b0;
        err     <= 1'b0;
      end
      if (addr_shift || len_shift || data_bit) begin
        par_acc <= par_acc ^ bit_val;
      end
      if (par_bit && (par_acc ^ bit_val)) begin
        err <= 1'b1;
      end
    end
  end

  assign io.err = err;
`endif

  assign io.port_sel    = port_sel;
  assign io.ser_out     = ser_out;
  assign io.SerOutValid = out_vld;
  assign io.done        = done;
  assign io.ssd_result  = ssd_glyph(4'(remain));

endmodule

// File: tb/tb_ser_demux_n.sv
// tb_ser_demux_n: self-checking bench for ser_demux_n. Packets are described at
// packet level (address, length, payload) and the expected channel, payload
// pulses, display values and done pulse are derived from that description.
module tb_ser_demux_n;

  localparam int ADDR_W      = 2;
  localparam int CNT_W       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int NCH         = 2 ** ADDR_W;
  localparam int HOLD        = SYNC_STAGES + 3;

  // Active-low {g,f,e,d,c,b,a} hex glyphs 0..F.
  localparam logic [6:0] GLYPH [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    int so;
    int ps;
    int ssd;
    int cyc;
  } ev_t;

  logic clock;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  int   last_rise;
  logic prev_err;

  ev_t  obs_v[$];
  int   obs_d[$];

  ser_demux_n_if #(.ADDR_W(ADDR_W)) io ();

  ser_demux_n #(
    .ADDR_W      (ADDR_W),
    .CNT_W       (CNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Record every payload pulse and done pulse the design produces.
  always @(negedge clock) begin
    if (!reset) begin
      if (io.SerOutValid) begin
        obs_v.push_back('{so: int'(io.ser_out), ps: int'(io.port_sel),
                          ssd: int'(io.ssd_result), cyc: cyc});
      end
      if (io.done) obs_d.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic strobe(input logic b);
    @(negedge clock);
    io.SerIn  = b;
    io.clkPB  = 1'b1;
    last_rise = cyc;
    repeat (HOLD) @(negedge clock);
    io.clkPB = 1'b0;
    repeat (HOLD) @(negedge clock);
  endtask

  task automatic send_packet(input int a, input int len, input logic [15:0] payload,
                             input int idle, input logic par_flip, input logic chk_lat);
    logic [ADDR_W-1:0] av;
    logic [CNT_W-1:0]  lv;
    logic [15:0]       mask;
    logic              par;
    int                first_rise;
    int                exp_rem;
    av = ADDR_W'(a);
    lv = CNT_W'(len);
    first_rise = 0;
    obs_v.delete();
    obs_d.delete();
    for (int i = 0; i < idle; i++) strobe(1'b1);
    check_eq("idle_port_sel", io.port_sel, 0);
    check_eq("idle_events", obs_v.size() + obs_d.size(), 0);
`ifdef PARITY_EN
    if (idle > 0) check_eq("err_sticky", io.err, prev_err);
`endif
    strobe(1'b0);
`ifdef PARITY_EN
    check_eq("err_clear_on_start", io.err, 0);
`endif
    for (int i = ADDR_W - 1; i >= 0; i--) strobe(av[i]);
    check_eq("port_sel_after_addr", io.port_sel, 1 << a);
    for (int i = CNT_W - 1; i >= 0; i--) strobe(lv[i]);
    check_eq("ssd_after_len", io.ssd_result, GLYPH[len % 16]);
    for (int k = 0; k < len; k++) begin
      strobe(payload[k]);
      if (k == 0) first_rise = last_rise;
    end
`ifdef PARITY_EN
    mask = 16'((32'd1 << len) - 1);
    par  = (^av) ^ (^lv) ^ (^(payload & mask)) ^ par_flip;
    strobe(par);
`else
    mask = '0;
    par  = par_flip;
`endif
    repeat (4) @(negedge clock);
    check_eq("valid_count", obs_v.size(), len);
    for (int k = 0; k < len && k < obs_v.size(); k++) begin
      exp_rem = len - 1 - k;
      check_eq("ser_out", obs_v[k].so, int'(payload[k]) << a);
      check_eq("port_sel_hold", obs_v[k].ps, 1 << a);
      check_eq("ssd_count", obs_v[k].ssd, GLYPH[exp_rem % 16]);
    end
    check_eq("done_count", obs_d.size(), 1);
    if (chk_lat && len > 0 && obs_v.size() > 0)
      check_eq("first_bit_latency", obs_v[0].cyc - first_rise, SYNC_STAGES + 2);
`ifndef PARITY_EN
    if (len > 0 && obs_v.size() == len && obs_d.size() > 0)
      check_eq("done_latency", obs_d[0] - obs_v[len-1].cyc, 1);
`else
    check_eq("err_after_packet", io.err, par_flip);
    prev_err = par_flip;
`endif
    check_eq("port_sel_end", io.port_sel, 0);
    check_eq("ser_out_end", io.ser_out, 0);
    check_eq("ssd_end", io.ssd_result, GLYPH[0]);
  endtask

  task automatic reset_mid_packet();
    obs_v.delete();
    obs_d.delete();
    strobe(1'b0);
    strobe(1'b1); strobe(1'b0);                               // addr 2
    strobe(1'b0); strobe(1'b1); strobe(1'b0); strobe(1'b0);   // length 4
    strobe(1'b0); strobe(1'b1);                               // two payload bits
    check_eq("pre_rst_port_sel", io.port_sel, 4);
    check_eq("pre_rst_ser_out", io.ser_out, 4);
    check_eq("pre_rst_ssd", io.ssd_result, GLYPH[2]);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("rst_port_sel", io.port_sel, 0);
    check_eq("rst_ser_out", io.ser_out, 0);
    check_eq("rst_valid", io.SerOutValid, 0);
    check_eq("rst_done", io.done, 0);
    check_eq("rst_ssd", io.ssd_result, GLYPH[0]);
`ifdef PARITY_EN
    check_eq("rst_err", io.err, 0);
    prev_err = 1'b0;
`endif
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    cyc      = 0;
    prev_err = 1'b0;
    io.SerIn = 1'b1;
    io.clkPB = 1'b0;
    reset    = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("reset_port_sel", io.port_sel, 0);
    check_eq("reset_ser_out", io.ser_out, 0);
    check_eq("reset_valid", io.SerOutValid, 0);
    check_eq("reset_done", io.done, 0);
    check_eq("reset_ssd", io.ssd_result, 7'b1000000);
`ifdef PARITY_EN
    check_eq("reset_err", io.err, 0);
`endif
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Canonical packet: addr 2, length 3, payload 0,1,0, framed by idle 1s.
    send_packet(2, 3, 16'b010, 2, 1'b0, 1'b1);
    // Zero length on the top channel.
    send_packet(3, 0, 16'h0000, 0, 1'b0, 1'b0);
    // Maximum length on channel 0.
    send_packet(0, 15, 16'h5A3C, 1, 1'b0, 1'b1);
    // Back-to-back: addr 1, length 1 straight after done.
    send_packet(1, 1, 16'h0001, 0, 1'b0, 1'b0);
`ifdef PARITY_EN
    // Canonical packet with a deliberately wrong parity bit, then a clean one.
    send_packet(2, 3, 16'b010, 0, 1'b1, 1'b0);
    send_packet(2, 3, 16'b010, 2, 1'b0, 1'b0);
`endif
    reset_mid_packet();
    send_packet(2, 3, 16'b010, 1, 1'b0, 1'b1);

    for (int n = 0; n < 25; n++) begin
      send_packet($urandom_range(0, NCH - 1), $urandom_range(0, 15),
                  16'($urandom), $urandom_range(0, 2),
`ifdef PARITY_EN
                  1'($urandom_range(0, 1)),
`else
                  1'b0,
`endif
                  1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ser_demux_n.md
# ser_demux_n

Parametrised serial packet demultiplexer, the successor to the fixed 4-port MSSD block. It takes a bit stream on `SerIn`, clocked bit by bit with the `clkPB` push-button strobe. Each packet is a start bit, a channel address field, a length field and a payload. The payload is routed to one of 2^ADDR_W output channels, and the remaining length is shown on a seven-segment digit. It sits between the board push-button/switch inputs and the channel LEDs and SSD driver.

## Interface
- `ADDR_W`, default 2: address field width; channel count `NCH = 2**ADDR_W`.
- `CNT_W`, default 4: length field width; maximum payload is 2^CNT_W−1 bits.
- `SYNC_STAGES`, default 2: synchroniser depth for `clkPB` and `SerIn` (minimum 2).

Ports:
- `clock` in 1: system clock; all state is updated on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `SerIn` in 1: serial data, asynchronous to `clock`.
- `clkPB` in 1: bit strobe; each rising edge samples one bit. Asynchronous, pre-debounced.
- `port_sel` out NCH: one-hot selected channel, held from the end of the address field until `done`.
- `ser_out` out NCH: routed payload bit; only bit `addr` is nonzero.
- `SerOutValid` out 1: one-clock pulse per payload bit delivered.
- `done` out 1: one-clock pulse at the end of a packet.
- `ssd_result` out 7: remaining payload count, low 4 bits, hex glyph. Active-low, bit order {g,f,e,d,c,b,a}.
- `err` out 1 (`PARITY_EN` only): sticky parity error; cleared by the next start bit.

## Operation
- **Bit strobe.** `clkPB` and `SerIn` each pass through SYNC_STAGES flops. `bit_en` is a one-clock pulse on the synchronised rising edge of `clkPB`. The sampled bit is the synchronised `SerIn` in the same cycle.
- **IDLE.**
  - `bit_en` with bit=0 → ADDR, and clear the shift counter.
  - bit=1 is ignored (line idle).
- **ADDR.**
  - Shift ADDR_W bits in, MSB first.
  - After the last bit, latch `addr` → LEN, and drive `port_sel` = 1<<addr.
- **LEN.**
  - Shift CNT_W bits in, MSB first, into `remain`.
  - After the last bit: if the value is 0 → END, otherwise → DATA.
- **DATA.**
  - Each `bit_en`: `ser_out` ← bit in position `addr` (all other positions 0); pulse `SerOutValid`; `remain` ← `remain`−1.
  - When `remain` was 1 → END.
- **END.**
  - Pulse `done` for one clock.
  - Clear `port_sel`, `ser_out` and `remain`.
  - Return to IDLE.
- **Display.** `ssd_result` always shows `remain[3:0]`.
  - 0 → 1000000
  - 1 → 1111001
  - 2 → 0100100
  - 3 → 0110000
  - 4–F use the standard hex glyphs.
- **Arithmetic.** `remain` is CNT_W bits and never decrements below 0. The bit counter is max(ADDR_W,CNT_W)-bit and wraps only on field boundaries.
- **Boundary cases.**
  - `bit_en` arriving in the same clock as the END pulse cannot happen: END lasts one clock, and strobes are ≥ SYNC_STAGES+1 clocks apart.
  - A further `clkPB` edge after `done` with bit=1 is ignored.
  - A bit=0 after `done` starts a new packet.
  - `reset` mid-packet returns to IDLE immediately and drops all outputs in the same cycle.

## Timing
- **Reset values:** state IDLE, `port_sel`=0, `ser_out`=0, `SerOutValid`=0, `done`=0, `remain`=0, `ssd_result`=7'b1000000, `err`=0.
- **Latency:**
  - `clkPB` rising → `bit_en`: SYNC_STAGES+1 clocks.
  - `bit_en` → registered outputs (`ser_out`, `SerOutValid`, `port_sel`, `ssd_result`): 1 clock.
  - Last payload `bit_en` → `done`: 2 clocks (DATA→END, then END asserts `done`).
- **`ser_out` hold:** holds its value until the next payload bit or END.
- **Rate:** no backpressure. A consumer must accept each `SerOutValid` pulse in the same cycle.

## Configuration
- **`PARITY_EN` defined:**
  - One extra bit follows the payload, in state PAR.
  - The packet uses even parity over the address, length and payload bits.
  - A mismatch sets `err`.
  - `done` still pulses after PAR.
  - A zero-length packet still carries a parity bit.
- **`PARITY_EN` undefined:**
  - There is no PAR state and no `err` port.
  - Timing is exactly as in Operation.

## Structure
- **Package `ser_demux_pkg`:**
  - state enum IDLE/ADDR/LEN/DATA/PAR/END
  - `SSD_GLYPH` 16×7 constant
  - the SYNC_STAGES minimum constant
- **Sub-module `pb_edge_sync`:** synchroniser chain plus rising-edge detector producing `bit_en` and the synced data bit. Instantiated once.

## Test plan
- **Canonical packet.**
  - Stimulus: `reset` pulse, then `clkPB` strobes with SerIn = 0,1,0,0,0,1,1,0,1,0, then 1s.
  - `port_sel`=0100 after bit 3.
  - `ssd_result`=0110000 (3) after bit 7.
  - `SerOutValid` pulses 3 times, with `ser_out[2]`=0,1,0.
  - `done` pulses once, 2 clocks after the last payload strobe; `ssd_result` returns to 1000000.
- **Zero length.**
  - Stimulus: start, addr 11, length 0000.
  - Response: no `SerOutValid`; `done` pulse; `port_sel` returns to 0.
- **Maximum length.**
  - Stimulus: start, addr 00, length 1111, 15 payload bits.
  - Response: SSD steps F→0; exactly 15 valid pulses, all on `ser_out[0]`.
- **Idle and back-to-back packets.**
  - Stimulus: SerIn=1 strobes before and after a packet; a second packet with addr 01, length 0001 immediately after `done`.
  - Response: idle strobes are ignored; the second packet routes to `ser_out[1]`.
- **Reset mid-packet.**
  - Stimulus: assert `reset` during DATA with remain=2.
  - Response: all outputs are at reset values within the same cycle; the next packet decodes normally.
- **`PARITY_EN` parity check.**
  - Stimulus: canonical packet with a correct parity bit, then the same packet with a flipped parity bit.
  - Response: `err` stays 0 for the first packet; for the second, `err`=1 and stays set until the next start bit.
